// File: rtl/fft_stage_sequencer_if.sv
// rtl/fft_stage_sequencer_if.sv - control bundle between the FFT stage sequencer and the SDF datapath
interface fft_stage_sequencer_if #(
   parameter int N_STAGES = 4,
   parameter int ADDR_W   = 5
);
   logic                         in_valid;
   logic [N_STAGES-1:0]          stage_en;
   logic [N_STAGES-1:0]          sw_ctrl;
   logic [N_STAGES*ADDR_W-1:0]   coef_addr;
   logic                         out_valid;
   logic [1:0]                   state;
   logic [15:0]                  frame_cnt;

   // Sequencer side: consumes the input strobe, drives every stage control.
   modport master (
      input  in_valid,
      output stage_en, sw_ctrl, coef_addr, out_valid, state, frame_cnt
   );

   // Datapath side: presents the input strobe, receives the stage controls.
   modport slave (
      output in_valid,
      input  stage_en, sw_ctrl, coef_addr, out_valid, state, frame_cnt
   );
endinterface

// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - per-stage enable, commutator and coefficient address sequencer for a radix-2 SDF FFT (optional frame counter: FFT_SEQ_FRAME_CNT_EN)
module fft_stage_sequencer #(
   parameter int N_STAGES    = 4,
   parameter int FIRST_DELAY = 24,
   parameter int P0          = 8,
   parameter int COEF_DEPTH  = 32,
   parameter int ADDR_W      = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   fft_stage_sequencer_if.master  bus
);

   // Stage k sees in_valid delayed by FIRST_DELAY plus the half-periods of all earlier stages.
   function automatic int stage_delay(input int k);
      int d;
      d = FIRST_DELAY;
      for (int i = 0; i < k; i++) d += (P0 >> i);
      return d;
   endfunction

   localparam int D_MAX = stage_delay(N_STAGES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   // tap[j] is in_valid as it was j cycles ago; tap[0] is the live input.
   logic [D_MAX-1:0]    hist;
   logic [D_MAX:0]      tap;
   logic [N_STAGES-1:0] en_cur;
   logic [N_STAGES-1:0] en_nxt;
   state_t              state_q;
   state_t              state_d;

   assign tap = {hist, bus.in_valid};

   // One shared delay line serves every stage, so any in_valid pattern is reproduced exactly.
   always_ff @(posedge clk) begin
      if (rst) hist <= '0;
      else     hist <= tap[D_MAX-1:0];
   end

   for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
      localparam int DK = stage_delay(k);
      localparam int PK = P0 >> k;
      localparam int PW = (PK > 1) ? $clog2(PK) : 1;

      logic [PW-1:0]     phase_q;
      logic              sw_q;
      logic [ADDR_W-1:0] addr_q;
      logic              last_phase;

      // en_nxt is the value stage_en[k] takes after this edge, so phase/address
      // restart exactly on the first enabled cycle of every burst.
      assign en_cur[k]  = tap[DK];
      assign en_nxt[k]  = tap[DK-1];
      assign last_phase = (phase_q == PW'(PK - 1));

      // Phase counter, commutator toggle and coefficient address advance only across two enabled cycles.
      always_ff @(posedge clk) begin
         if (rst || !(en_cur[k] && en_nxt[k])) begin
            phase_q <= '0;
            sw_q    <= 1'b0;
            addr_q  <= '0;
         end else begin
            phase_q <= last_phase ? '0 : phase_q + 1'b1;
            if (last_phase) sw_q <= ~sw_q;
            addr_q  <= (addr_q == ADDR_W'(COEF_DEPTH - 1)) ? '0 : addr_q + 1'b1;
         end
      end

      assign bus.sw_ctrl[k]                    = sw_q;
      assign bus.coef_addr[k*ADDR_W +: ADDR_W] = addr_q;
   end

   assign bus.stage_en  = en_cur;
   assign bus.out_valid = en_cur[N_STAGES-1];
   assign bus.state     = state_q;

`ifdef FFT_SEQ_FRAME_CNT_EN
   logic [15:0] frame_q;
   logic        wrap_last;

   assign wrap_last = en_cur[N_STAGES-1] && en_nxt[N_STAGES-1] &&
                      (bus.coef_addr[(N_STAGES-1)*ADDR_W +: ADDR_W] == ADDR_W'(COEF_DEPTH - 1));

   // Count last-stage address wraps, holding at all-ones instead of rolling over.
   always_ff @(posedge clk) begin
      if (rst)                                frame_q <= '0;
      else if (wrap_last && frame_q != 16'hFFFF) frame_q <= frame_q + 16'd1;
   end

   assign bus.frame_cnt = frame_q;
`else
   assign bus.frame_cnt = '0;
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state from the live input and the registered stage enables; a drop of in_valid wins over a last-stage rise.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.in_valid) state_d = FILL;
         FILL:    if (!bus.in_valid)                state_d = DRAIN;
                  else if (en_cur[N_STAGES-1])      state_d = RUN;
         RUN:     if (!bus.in_valid)                state_d = DRAIN;
         DRAIN:   if (bus.in_valid)                 state_d = en_cur[N_STAGES-1] ? RUN : FILL;
                  else if (en_cur == '0)            state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb/tb_fft_stage_sequencer.sv - randomized self-checking bench for fft_stage_sequencer (honours FFT_SEQ_FRAME_CNT_EN)
module tb_fft_stage_sequencer;
   localparam int N_STAGES    = 4;
   localparam int FIRST_DELAY = 24;
   localparam int P0          = 8;
   localparam int COEF_DEPTH  = 32;
   localparam int ADDR_W      = 5;
   localparam int MAXC        = 4096;
   localparam int RAND_END    = 3000;

   logic clk = 1'b0;
   logic rst;

   fft_stage_sequencer_if #(.N_STAGES(N_STAGES), .ADDR_W(ADDR_W)) bus ();

   fft_stage_sequencer #(
      .N_STAGES   (N_STAGES),
      .FIRST_DELAY(FIRST_DELAY),
      .P0         (P0),
      .COEF_DEPTH (COEF_DEPTH),
      .ADDR_W     (ADDR_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int t      = 0;
   int base   = 0;
   bit iv [MAXC];
   int dly [N_STAGES];
   int per [N_STAGES];
   int run_len [N_STAGES];
   int st_m;
   int fc_m;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, t, obs, exp);
      end
   endtask

   // Stage k is enabled in cycle c iff in_valid was high D_k cycles earlier, after the last reset.
   function automatic bit en_m(input int k, input int c);
      if (c - dly[k] < base) return 1'b0;
      return iv[c - dly[k]];
   endfunction

   task automatic step(input bit r, input bit v);
      logic [N_STAGES-1:0]        e_en;
      logic [N_STAGES-1:0]        e_sw;
      logic [N_STAGES*ADDR_W-1:0] e_addr;
      bit                         last_now;
      bit                         last_nxt;
      @(posedge clk);
      #1;
      rst          = r;
      bus.in_valid = v;
      iv[t]        = v;
      @(negedge clk);
      for (int k = 0; k < N_STAGES; k++) begin
         e_en[k]    = en_m(k, t);
         run_len[k] = e_en[k] ? run_len[k] + 1 : 0;
         e_sw[k]    = (run_len[k] > 0) ? 1'(((run_len[k] - 1) / per[k]) % 2) : 1'b0;
         e_addr[k*ADDR_W +: ADDR_W] = (run_len[k] > 0) ? ADDR_W'((run_len[k] - 1) % COEF_DEPTH) : '0;
      end
      check("stage_en",  64'(bus.stage_en),  64'(e_en));
      check("out_valid", 64'(bus.out_valid), 64'(e_en[N_STAGES-1]));
      check("sw_ctrl",   64'(bus.sw_ctrl),   64'(e_sw));
      check("coef_addr", 64'(bus.coef_addr), 64'(e_addr));
      check("state",     64'(bus.state),     64'(st_m));
`ifdef FFT_SEQ_FRAME_CNT_EN
      check("frame_cnt", 64'(bus.frame_cnt), 64'(fc_m));
`else
      check("frame_cnt", 64'(bus.frame_cnt), 64'(0));
`endif
      if (r) begin
         base = t + 1;
         st_m = 0;
         fc_m = 0;
      end else begin
         last_now = e_en[N_STAGES-1];
         last_nxt = en_m(N_STAGES - 1, t + 1);
         if (last_now && last_nxt && ((run_len[N_STAGES-1] - 1) % COEF_DEPTH == COEF_DEPTH - 1) && fc_m < 65535)
            fc_m++;
         case (st_m)
            0: if (v) st_m = 1;
            1: if (!v) st_m = 3; else if (last_now) st_m = 2;
            2: if (!v) st_m = 3;
            3: if (v) st_m = last_now ? 2 : 1; else if (e_en == '0) st_m = 0;
            default: st_m = 0;
         endcase
      end
      t++;
   endtask

   initial begin
      int  len;
      int  mode;
      bit  val;
      dly[0] = FIRST_DELAY;
      for (int k = 0; k < N_STAGES; k++) begin
         per[k]     = P0 >> k;
         run_len[k] = 0;
         if (k > 0) dly[k] = dly[k-1] + per[k-1];
      end
      st_m         = 0;
      fc_m         = 0;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);

      // reset and idle
      repeat (3) step(1'b1, 1'b0);
      repeat (2) step(1'b0, 1'b0);
      // continuous fill, run, address wraps and drain
      repeat (100) step(1'b0, 1'b1);
      repeat (60) step(1'b0, 1'b0);
      // single-cycle pulse
      repeat (5) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      repeat (60) step(1'b0, 1'b0);
      // reset during RUN, then idle input
      repeat (45) step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      repeat (60) step(1'b0, 1'b0);

      // random bursts, gaps, jitter and occasional resets
      while (t < RAND_END) begin
         len  = $urandom_range(1, 90);
         mode = $urandom_range(0, 2);
         val  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 30) == 0) step(1'b1, 1'b0);
         for (int i = 0; i < len; i++) begin
            if (t < RAND_END) begin
               if (mode == 2) step(1'b0, 1'($urandom_range(0, 1)));
               else           step(1'b0, val);
            end
         end
      end
      repeat (50) step(1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
